// File: rtl/pipe_in_arbiter.sv
// pipe_in_arbiter: round-robin share of one PipeIn enq channel among NUM_REQ
// indication sources, with a 1-entry registered output stage.
// Optional build macro PIPE_ARB_LOCK_EN keeps multi-beat messages atomic
// (req_last marks the final beat); without it req_last is ignored.
module pipe_in_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            req_enq__ENA,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_enq_v,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_enq__RDY,
  output logic                          pipe_enq__ENA,
  output logic [DATA_WIDTH-1:0]         pipe_enq_v,
  input  logic                          pipe_enq__RDY
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic [IDX_W-1:0]      rr_ptr;
  logic                  can_load;
  logic                  grant_any;
  logic [IDX_W-1:0]      grant_idx;
  logic [IDX_W-1:0]      scan_idx;
  logic [DATA_WIDTH-1:0] sel_data;

`ifdef PIPE_ARB_LOCK_EN
  logic                  lock;
  logic [IDX_W-1:0]      lock_id;
`else
  logic                  unused_last;
  assign unused_last = ^req_last;
`endif

  // Output stage can take a beat when empty or being drained this cycle
  assign can_load      = !out_valid || pipe_enq__RDY;
  assign pipe_enq__ENA = out_valid;
  assign pipe_enq_v    = out_data;

  // Grant selection: locked owner only, else first requester after rr_ptr
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    if (can_load) begin
`ifdef PIPE_ARB_LOCK_EN
      if (lock) begin
        if (req_enq__ENA[lock_id]) begin
          grant_any = 1'b1;
          grant_idx = lock_id;
        end
      end else
`endif
      begin
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
          scan_idx = IDX_W'((int'(rr_ptr) + k) % int'(NUM_REQ));
          if (!grant_any && req_enq__ENA[scan_idx]) begin
            grant_any = 1'b1;
            grant_idx = scan_idx;
          end
        end
      end
    end
  end

  // One-hot ready to the granted requester and its beat data
  always_comb begin
    req_enq__RDY = '0;
    sel_data     = '0;
    if (grant_any) begin
      req_enq__RDY = NUM_REQ'(1) << grant_idx;
    end
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_data = req_enq_v[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Output register and round-robin pointer
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      rr_ptr    <= IDX_W'(NUM_REQ - 1);
    end else begin
      if (grant_any) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
`ifdef PIPE_ARB_LOCK_EN
        if (!lock) begin
          rr_ptr <= grant_idx;
        end
`else
        rr_ptr <= grant_idx;
`endif
      end else if (out_valid && pipe_enq__RDY) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef PIPE_ARB_LOCK_EN
  // Message lock: held from a non-last grant until the owner's last beat
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lock    <= 1'b0;
      lock_id <= '0;
    end else if (grant_any) begin
      if (!lock && !req_last[grant_idx]) begin
        lock    <= 1'b1;
        lock_id <= grant_idx;
      end else if (lock && req_last[grant_idx]) begin
        lock    <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_in_arbiter.sv
// Directed bench for pipe_in_arbiter (NUM_REQ=4, DATA_WIDTH=64).
// Expectations follow PIPE_ARB_LOCK_EN when the macro is defined.
module tb_pipe_in_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned W = 64;

  logic           CLK = 1'b0;
  logic           RST;
  logic [N-1:0]   req_enq__ENA;
  logic [N*W-1:0] req_enq_v;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_enq__RDY;
  logic           pipe_enq__ENA;
  logic [W-1:0]   pipe_enq_v;
  logic           pipe_enq__RDY;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] exp_msg [5];
  logic [63:0] exp_gap [4];

  always #5 CLK = ~CLK;

  pipe_in_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .req_enq__ENA  (req_enq__ENA),
    .req_enq_v     (req_enq_v),
    .req_last      (req_last),
    .req_enq__RDY  (req_enq__RDY),
    .pipe_enq__ENA (pipe_enq__ENA),
    .pipe_enq_v    (pipe_enq_v),
    .pipe_enq__RDY (pipe_enq__RDY)
  );

  // Count one comparison and report it if it differs
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_v(input int i, input logic [63:0] d);
    req_enq_v[i*W +: W] = d;
  endtask

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0] g;
    int p0, p1, p2, p3, stall, got;

`ifdef PIPE_ARB_LOCK_EN
    exp_msg[0] = 64'hB1; exp_msg[1] = 64'hB2; exp_msg[2] = 64'hB3;
    exp_msg[3] = 64'hC1; exp_msg[4] = 64'hC2;
    exp_gap[0] = 64'hD1; exp_gap[1] = 64'hD2; exp_gap[2] = 64'hD3; exp_gap[3] = 64'hE1;
`else
    exp_msg[0] = 64'hB1; exp_msg[1] = 64'hC1; exp_msg[2] = 64'hB2;
    exp_msg[3] = 64'hC2; exp_msg[4] = 64'hB3;
    exp_gap[0] = 64'hD1; exp_gap[1] = 64'hE1; exp_gap[2] = 64'hD2; exp_gap[3] = 64'hD3;
`endif

    RST           = 1'b1;
    req_enq__ENA  = '0;
    req_enq_v     = '0;
    req_last      = '0;
    pipe_enq__RDY = 1'b1;
    step();
    step();
    check("rst_ena", 64'(pipe_enq__ENA), 64'd0);
    check("rst_data", pipe_enq_v, 64'd0);
    check("rst_rdy", 64'(req_enq__RDY), 64'd0);
    RST = 1'b0;

    // Single source on req2
    req_enq__ENA = 4'b0100;
    set_v(2, 64'h11);
    #1;
    check("single_rdy", 64'(req_enq__RDY), 64'h4);
    step();
    check("single_ena", 64'(pipe_enq__ENA), 64'd1);
    check("single_data", pipe_enq_v, 64'h11);
    req_enq__ENA = '0;
    #1;
    check("single_idle_rdy", 64'(req_enq__RDY), 64'd0);
    step();
    check("single_drain", 64'(pipe_enq__ENA), 64'd0);

    // Reset while a beat is held
    req_enq__ENA  = 4'b0001;
    set_v(0, 64'h22);
    pipe_enq__RDY = 1'b0;
    step();
    check("mid_loaded", 64'(pipe_enq__ENA), 64'd1);
    req_enq__ENA = '0;
    #2;
    RST = 1'b1;
    #1;
    check("mid_rst_ena", 64'(pipe_enq__ENA), 64'd0);
    check("mid_rst_data", pipe_enq_v, 64'd0);
    step();
    RST = 1'b0;
    pipe_enq__RDY = 1'b1;

    // Fairness: all requesting, first grant to req0 after reset
    req_enq__ENA = 4'b1111;
    for (int i = 0; i < 4; i++) set_v(i, 64'hA0 + 64'(i));
    for (int k = 0; k < 6; k++) begin
      #1;
      check("fair_rdy", 64'(req_enq__RDY), 64'(1) << (k % 4));
      step();
      check("fair_ena", 64'(pipe_enq__ENA), 64'd1);
      check("fair_data", pipe_enq_v, 64'hA0 + 64'(k % 4));
    end

    // Backpressure: hold A1 for 5 cycles, then req2 loads on release
    pipe_enq__RDY = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_rdy", 64'(req_enq__RDY), 64'd0);
      check("bp_data", pipe_enq_v, 64'hA1);
      step();
    end
    pipe_enq__RDY = 1'b1;
    #1;
    check("bp_release_rdy", 64'(req_enq__RDY), 64'h4);
    step();
    check("bp_release_data", pipe_enq_v, 64'hA2);
    req_enq__ENA = '0;
    step();
    check("bp_drain", 64'(pipe_enq__ENA), 64'd0);

    // Multi-beat message from req1 while req2 competes
    p1 = 0; p2 = 0; got = 0;
    for (int c = 0; c < 10; c++) begin
      req_enq__ENA = '0;
      req_last     = '0;
      req_enq__ENA[1] = (p1 < 3);
      set_v(1, 64'hB1 + 64'(p1));
      req_last[1] = (p1 == 2);
      req_enq__ENA[2] = (p2 < 2);
      set_v(2, 64'hC1 + 64'(p2));
      req_last[2] = (p2 == 1);
      #1;
      g = req_enq__RDY;
      if (g[1]) p1++;
      if (g[2]) p2++;
      step();
      if (g != '0) begin
        check("msg_ena", 64'(pipe_enq__ENA), 64'd1);
        if (got < 5) check("msg_data", pipe_enq_v, exp_msg[got]);
        got++;
      end else begin
        check("msg_idle_ena", 64'(pipe_enq__ENA), 64'd0);
      end
    end
    check("msg_count", 64'(got), 64'd5);

    // Idle gap: req3 stalls 2 cycles after its first beat, req0 waits
    p0 = 0; p3 = 0; stall = 0; got = 0;
    for (int c = 0; c < 10; c++) begin
      req_enq__ENA = '0;
      req_last     = '0;
      req_enq__ENA[3] = (p3 < 3) && (stall == 0);
      set_v(3, 64'hD1 + 64'(p3));
      req_last[3] = (p3 == 2);
      req_enq__ENA[0] = (c >= 1) && (p0 < 1);
      set_v(0, 64'hE1);
      req_last[0] = 1'b1;
      #1;
      g = req_enq__RDY;
`ifdef PIPE_ARB_LOCK_EN
      if (c == 1 || c == 2) check("gap_lock_rdy", 64'(g), 64'd0);
`endif
      if (g[3]) begin
        p3++;
        if (p3 == 1) stall = 2;
      end else if (stall > 0) begin
        stall--;
      end
      if (g[0]) p0++;
      step();
      if (g != '0) begin
        check("gap_ena", 64'(pipe_enq__ENA), 64'd1);
        if (got < 4) check("gap_data", pipe_enq_v, exp_gap[got]);
        got++;
      end else begin
        check("gap_idle_ena", 64'(pipe_enq__ENA), 64'd0);
      end
    end
    check("gap_count", 64'(got), 64'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
